cla_sum_stage: RTL and testbench

- Final stage of the pipelined carry-lookahead adder. Sits directly downstream of the 7-register parallel-prefix carry network.
- Takes the resolved per-bit carry codes and the two operands that travelled alongside them, then forms the sum and carry-out.
- Results are registered and buffered in a small output FIFO with a ready/valid interface to the consumer.
- The prefix pipeline cannot stall, so overflow is detected and counted, not back-pressured.

---
 rtl/cla_sum_stage.sv | 86 ++++++++
 tb/tb_cla_sum_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_sum_stage.sv
// cla_sum_stage: final CLA stage, sums resolved carries into a drop-counting output FIFO.
// Optional macro KPG_CHECK_EN adds code_err for carry codes other than 'k'/'g'.
module cla_sum_stage #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH*8-1:0] y,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               almost_full,
`ifdef KPG_CHECK_EN
  output logic               code_err,
`endif
  output logic [CNT_W-1:0]   drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] sum_d;
  logic             s1_valid_q, s1_cout_q, almost_full_q;
  logic [WIDTH-1:0] s1_sum_q;
  logic [WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             pop, push, drop, full;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_code
      assign gen[i] = y[8*i +: 8] == 8'h67;
    end
  endgenerate
`ifdef KPG_CHECK_EN
  logic [WIDTH-1:0] bad;
  logic             code_err_q;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bad
      assign bad[i] = !(y[8*i +: 8] == 8'h67 || y[8*i +: 8] == 8'h6B);
    end
  endgenerate
  always_ff @(posedge clk) code_err_q <= !rst && in_valid && |bad;
  assign code_err = code_err_q;
`endif
  // carry into bit i is the generate status of bit i-1; anything but 'g' means no carry
  assign sum_d   = c ^ d ^ {gen[WIDTH-2:0], 1'b0};
  assign full    = count_q == (AW+1)'(DEPTH);
  assign pop     = out_valid && out_ready;
  assign push    = s1_valid_q && (!full || pop);
  assign drop    = s1_valid_q && full && !pop;
  assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sum_q      <= '0;
      s1_cout_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      s1_valid_q    <= in_valid;
      s1_sum_q      <= in_valid ? sum_d : s1_sum_q;
      s1_cout_q     <= in_valid ? gen[WIDTH-1] : s1_cout_q;
      wr_ptr_q      <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q      <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q       <= count_d;
      almost_full_q <= count_d >= (AW+1)'(DEPTH-1);
      drop_cnt_q    <= (drop && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= {s1_cout_q, s1_sum_q};
  end
  assign out_valid             = count_q != '0;
  assign {out_cout, out_sum}   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign almost_full           = almost_full_q;
  assign drop_cnt              = drop_cnt_q;
endmodule

// File: tb/tb_cla_sum_stage.sv
// tb_cla_sum_stage: random and directed stimulus against a queue-based reference of the adder and FIFO.
module tb_cla_sum_stage;
  localparam int W = 64;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, out_valid, out_cout, almost_full;
  logic [W*8-1:0] y;
  logic [W-1:0] c, d, out_sum;
  logic [15:0] drop_cnt;
`ifdef KPG_CHECK_EN
  logic code_err;
`endif
  int errors = 0, checks = 0;
  logic [W:0] sb [$];
  int occ = 0, mdrop = 0;
  logic s1v = 1'b0, merr = 1'b0, cur_bad = 1'b0;
  logic [W:0] s1e, cur_exp;

  cla_sum_stage #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .y(y), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .almost_full(almost_full),
`ifdef KPG_CHECK_EN
    .code_err(code_err),
`endif
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // carry codes consistent with true binary addition: 'g' where bit i carries out
  function automatic logic [W*8-1:0] codes(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W*8-1:0] r;
    logic [W:0] m, t;
    for (int i = 0; i < W; i++) begin
      m = ((W+1)'(1) << (i + 1)) - (W+1)'(1);
      t = ({1'b0, a} & m) + ({1'b0, b} & m);
      r[8*i +: 8] = t[i+1] ? 8'h67 : 8'h6B;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    c = a;
    d = b;
    y = codes(a, b);
    cur_exp = {1'b0, a} + {1'b0, b};
    cur_bad = 1'b0;
    in_valid = 1'b1;
  endtask

  // reference: one stage of latency, then a DEPTH-entry queue that drops when full without a pop
  initial begin
    logic pop, push;
    forever begin
      @(posedge clk);
      if (rst) begin
        occ = 0;
        mdrop = 0;
        s1v = 1'b0;
        merr = 1'b0;
        sb.delete();
      end else begin
        pop = occ > 0 && out_ready;
        push = 1'b0;
        if (s1v) begin
          if (occ < DEPTH || pop) begin
            sb.push_back(s1e);
            push = 1'b1;
          end else if (mdrop < 65535) mdrop++;
        end
        occ = occ + int'(push) - int'(pop);
        s1v = in_valid;
        s1e = cur_exp;
        merr = in_valid && cur_bad;
      end
    end
  end

  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      check("out_valid", (W+1)'(out_valid), (W+1)'(occ != 0));
      check("almost_full", (W+1)'(almost_full), (W+1)'(occ >= DEPTH - 1));
      check("drop_cnt", (W+1)'(drop_cnt), (W+1)'(mdrop));
`ifdef KPG_CHECK_EN
      check("code_err", (W+1)'(code_err), (W+1)'(merr));
`endif
      if (out_valid && out_ready && !rst) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: got %h expected no result", {out_cout, out_sum});
        end else begin
          e = sb.pop_front();
          check("head", {out_cout, out_sum}, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    c = '0;
    d = '0;
    y = '0;
    cur_exp = '0;
    tick();
    tick();
    check("reset_sum", {out_cout, out_sum}, '0);
    check("reset_valid", (W+1)'(out_valid), '0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(64'd5, 64'd3);
    tick();
    in_valid = 1'b0;
    tick();
    check("basic_sum", {out_cout, out_sum}, (W+1)'(8));
    repeat (3) tick();
    send('1, 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    check("chain_sum", {out_cout, out_sum}, {1'b1, 64'd0});
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      send(64'(k), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("fill_drop", (W+1)'(drop_cnt), (W+1)'(2));
    check("fill_af", (W+1)'(almost_full), (W+1)'(1));
    check("fill_head", {out_cout, out_sum}, (W+1)'(1));
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    for (int k = 11; k <= 15; k++) begin
      send(64'(k), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (7) tick();
    check("fullpop_drop", (W+1)'(drop_cnt), (W+1)'(2));
    send(64'd5, 64'd3);
    y[8*10 +: 8] = 8'h70;
    cur_bad = 1'b1;
    tick();
    in_valid = 1'b0;
    cur_bad = 1'b0;
    repeat (3) tick();
    send(64'd1, 64'd1);
    y[7:0] = 8'h70;
    cur_exp = '0;
    cur_bad = 1'b1;
    tick();
    in_valid = 1'b0;
    cur_bad = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 21; k <= 24; k++) begin
      send(64'(k), 64'(k));
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", (W+1)'(out_valid), '0);
    check("rst_drop", (W+1)'(drop_cnt), '0);
    out_ready = 1'b1;
    repeat (5) tick();
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) != 0) send({$urandom, $urandom}, {$urandom, $urandom});
      else in_valid = 1'b0;
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && (sb.size() != 0 || occ != 0 || s1v); n++) tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
